// File: rtl/aca_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aca_mon_pkg
// Description : Shared constants and FSM state type for the ACA error monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package aca_mon_pkg;

    localparam int ACA_WIDTH = 16;
    localparam int ACA_CNT_W = 16;
    localparam int ACA_SUM_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_t;

endpackage
`default_nettype wire

// File: rtl/aca_ed_calc.sv
`default_nettype none
// ============================================================================
// Module      : aca_ed_calc
// Description : Stage 1 - exact sum and absolute error distance, registered
//               together with a valid bit.
// Revision    : 1.0 - initial release
// ============================================================================
module aca_ed_calc
    import aca_mon_pkg::*;
#(
    parameter int WIDTH = ACA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH:0]   i_res,
    output logic             o_valid,
    output logic [WIDTH:0]   o_ed
);

    logic [WIDTH:0] w_exact;
    logic [WIDTH:0] w_ed;
    logic           r_valid;
    logic [WIDTH:0] r_ed;

    assign w_exact = {1'b0, i_a} + {1'b0, i_b};
    assign w_ed    = (w_exact >= i_res) ? (w_exact - i_res) : (i_res - w_exact);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ed    <= '0;
        end else begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_ed <= w_ed;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_ed    = r_ed;

endmodule
`default_nettype wire

// File: rtl/aca_error_monitor.sv
`default_nettype none
// ============================================================================
// Module      : aca_error_monitor
// Description : Measures error statistics of a locked/approximate adder over a
//               run of num_samples operand pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module aca_error_monitor
    import aca_mon_pkg::*;
#(
    parameter int WIDTH = ACA_WIDTH,
    parameter int CNT_W = ACA_CNT_W,
    parameter int SUM_W = ACA_SUM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic [WIDTH:0]   result_o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH:0]   max_ed,
    output logic [SUM_W-1:0] sum_ed
);

    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_sample_cnt;
    logic             r_drain_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [WIDTH:0]   r_max_ed;
    logic [SUM_W-1:0] r_sum_ed;

    logic             w_ready;
    logic             w_xfer;
    logic             w_last;
    logic             w_start_ok;
    logic             w_s1_valid;
    logic [WIDTH:0]   w_s1_ed;
    logic [SUM_W:0]   w_sum_wide;

    assign w_ready    = (r_state == ST_RUN) && (r_sample_cnt < r_num);
    assign w_xfer     = in_valid && w_ready;
    assign w_last     = w_xfer && ((r_sample_cnt + CNT_W'(1)) == r_num);
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // An empty run leaves immediately; otherwise the final transfer ends it.
                if ((r_num == '0) || w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_drain_cnt  <= 1'b0;
            r_num        <= '0;
            r_sample_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= (r_state == ST_DRAIN) ? ~r_drain_cnt : 1'b0;
            if (w_start_ok) begin
                r_num        <= num_samples;
                r_sample_cnt <= '0;
            end else if (w_xfer) begin
                r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            end
        end
    end

    aca_ed_calc #(
        .WIDTH (WIDTH)
    ) u_ed_calc (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_xfer),
        .i_a     (add1_i),
        .i_b     (add2_i),
        .i_res   (result_o),
        .o_valid (w_s1_valid),
        .o_ed    (w_s1_ed)
    );

    // One spare bit catches the carry so the accumulator can clamp instead of wrap.
    assign w_sum_wide = {1'b0, r_sum_ed} + {{(SUM_W - WIDTH){1'b0}}, w_s1_ed};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
            r_max_ed  <= '0;
            r_sum_ed  <= '0;
        end else if (w_start_ok) begin
            r_err_cnt <= '0;
            r_max_ed  <= '0;
            r_sum_ed  <= '0;
        end else if (w_s1_valid) begin
            if ((w_s1_ed != '0) && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            if (w_s1_ed > r_max_ed) begin
                r_max_ed <= w_s1_ed;
            end
            r_sum_ed <= w_sum_wide[SUM_W] ? '1 : w_sum_wide[SUM_W-1:0];
        end
    end

    assign in_ready     = w_ready;
    assign busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done         = (r_state == ST_DONE);
    assign sample_count = r_sample_cnt;
    assign err_count    = r_err_cnt;
    assign max_ed       = r_max_ed;
    assign sum_ed       = r_sum_ed;

endmodule
`default_nettype wire
